// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register slave: FSM states, command byte
// layout and the default status-register address.
package spi_reg_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  localparam int         CMD_RW_BIT    = 7;
  localparam int         CMD_RSV_HI    = 6;
  localparam int         CMD_RSV_LO    = 4;
  localparam int         CMD_ADDR_HI   = 3;
  localparam int         CMD_ADDR_LO   = 0;
  localparam int         ADDR_W        = 4;
  localparam logic [3:0] STAT_ADDR_DEF = 4'hF;

  function automatic logic cmd_rsv_ok(input logic [7:0] cmd);
    return cmd[CMD_RSV_HI:CMD_RSV_LO] == '0;
  endfunction

endpackage

// File: rtl/spi_reg_slave_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value per bit.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 16-bit frames (command, data) into a flop-based
// register file, with a read-only status byte and frame-abort reporting.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int              NREG      = 16,
  parameter logic [ADDR_W-1:0] STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic              line_clk,
  input  logic              line_reset_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [7:0]        stat_in,
  output logic [7:0]        ctrl_out,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);

  logic w_sck_s, w_mosi_s, w_cs_s;
  logic r_sck_d, r_cs_d;
  logic [1:0] r_arm_cnt;
  logic w_rise, w_fall, w_cs_fall, w_shift_en;

  spi_state_e r_state, w_state_nxt;
  logic w_cmd_done, w_commit, w_abort, w_wr_ok, w_leave;

  logic [3:0]              r_bit_cnt;
  logic [6:0]              r_shift;
  logic [7:0]              r_cmd;
  logic [7:0]              r_rd_byte;
  logic                    r_rd_act;
  logic                    r_miso, r_miso_oe;
  logic                    r_wr_stb, r_frame_err;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [7:0]              r_wr_data;
  logic [NREG-1:0][7:0]    r_regs;
  logic [7:0]              w_byte;
  logic [ADDR_W-1:0]       w_cmd_addr, w_new_addr;
  logic [7:0]              w_rd_val;

  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(line_clk), .i_rst_n(line_reset_n), .i_d(sck),  .o_q(w_sck_s));
  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(line_clk), .i_rst_n(line_reset_n), .i_d(mosi), .o_q(w_mosi_s));
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(line_clk), .i_rst_n(line_reset_n), .i_d(cs_n), .o_q(w_cs_s));

  // The cs_n synchronizer shows its reset value for a few cycles after reset;
  // falls are only trusted once r_cs_d carries a genuinely sampled level, so a
  // frame cut by reset needs a fresh cs_n fall.
  assign w_cs_fall  = (r_arm_cnt == 2'd3) & r_cs_d & ~w_cs_s;
  assign w_rise     = w_sck_s & ~r_sck_d;
  assign w_fall     = ~w_sck_s & r_sck_d;
  assign w_shift_en = ((r_state == ST_CMD) || (r_state == ST_DATA)) && !w_cs_s && w_rise;

  assign w_byte     = {r_shift, w_mosi_s};
  assign w_cmd_addr = r_cmd[CMD_ADDR_HI:CMD_ADDR_LO];
  assign w_new_addr = w_byte[CMD_ADDR_HI:CMD_ADDR_LO];
  assign w_wr_ok    = r_cmd[CMD_RW_BIT] && cmd_rsv_ok(r_cmd) && (w_cmd_addr != STAT_ADDR)
                      && (32'(w_cmd_addr) < NREG);
  assign w_rd_val   = (w_new_addr == STAT_ADDR) ? stat_in :
                      (32'(w_new_addr) < NREG)  ? r_regs[w_new_addr] : 8'h00;

  always_ff @(posedge line_clk or negedge line_reset_n) begin
    if (!line_reset_n) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (w_rise && r_bit_cnt == 4'd7) begin
          w_state_nxt = ST_DATA;
          w_cmd_done  = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
          // a frame with reserved bits set is silently ignored, even when cut short
          w_abort     = cmd_rsv_ok(r_cmd);
        end else if (w_rise && r_bit_cnt == 4'd15) begin
          w_state_nxt = ST_DONE;
          w_commit    = w_wr_ok;
        end
      end
      ST_DONE: if (w_cs_s) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_leave = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);

  always_ff @(posedge line_clk or negedge line_reset_n) begin
    if (!line_reset_n) begin
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_arm_cnt   <= 2'd0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 7'd0;
      r_cmd       <= 8'd0;
      r_rd_byte   <= 8'd0;
      r_rd_act    <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_frame_err <= 1'b0;
      r_regs      <= '0;
    end else begin
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
      if (r_arm_cnt != 2'd3) r_arm_cnt <= r_arm_cnt + 2'd1;

      if (r_state == ST_IDLE && w_cs_fall) begin
        r_bit_cnt <= 4'd0;
      end else if (w_shift_en) begin
        r_shift <= w_byte[6:0];
        if (r_bit_cnt != 4'd15) r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      // read byte is frozen at the command boundary
      if (w_cmd_done) begin
        r_cmd     <= w_byte;
        r_rd_act  <= ~w_byte[CMD_RW_BIT] & cmd_rsv_ok(w_byte);
        r_rd_byte <= w_rd_val;
      end

      if (w_leave) begin
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else if (r_state == ST_DATA && w_fall && r_rd_act) begin
        r_miso    <= r_rd_byte[7];
        r_rd_byte <= {r_rd_byte[6:0], 1'b0};
        r_miso_oe <= 1'b1;
      end

      r_wr_stb    <= w_commit;
      r_frame_err <= w_abort;
      if (w_commit) begin
        r_wr_addr          <= w_cmd_addr;
        r_wr_data          <= w_byte;
        r_regs[w_cmd_addr] <= w_byte;
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign ctrl_out  = r_regs[0];
  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomized bench for spi_reg_slave: an SPI master drives frames and a
// register-array model predicts writes, read bytes, aborts and ctrl_out.
module tb_spi_reg_slave;

  localparam int HALF = 80;  // sck half period = 8 line_clk cycles (16x)

  logic       line_clk = 1'b0;
  logic       line_reset_n = 1'b0;
  logic       sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic [7:0] stat_in = 8'h00;
  logic       miso, miso_oe, wr_stb, frame_err;
  logic [7:0] ctrl_out, wr_data;
  logic [3:0] wr_addr;

  int         n_chk = 0, n_err = 0;
  int         wr_cnt = 0, ferr_cnt = 0;
  logic [11:0] wr_last = '0;
  logic [7:0] m_regs [16];
  logic [7:0] stat_mid = 8'h00;
  bit         mid_en = 1'b0;
  int         rst_bit = -1;

  always #5 line_clk = ~line_clk;

  spi_reg_slave dut (
    .line_clk(line_clk), .line_reset_n(line_reset_n), .sck(sck), .mosi(mosi),
    .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe), .stat_in(stat_in),
    .ctrl_out(ctrl_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err));

  always @(negedge line_clk) begin
    if (wr_stb) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= {wr_addr, wr_data};
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Master side of one frame; miso/oe are sampled at each sck rise.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                       output logic [15:0] mb, output logic [15:0] ob);
    logic [15:0] w;
    w  = {cmd, dat};
    mb = '0;
    ob = '0;
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15-i];
      if (i == rst_bit) begin
        line_reset_n = 1'b0;
        #20;
        chk("rst_mid.out", {miso, miso_oe, wr_stb, frame_err, ctrl_out}, 0);
        line_reset_n = 1'b1;
        #(HALF-20);
      end else begin
        #HALF;
      end
      if (mid_en && i == 10) stat_in = stat_mid;
      sck = 1'b1;
      mb[15-i] = miso;
      ob[15-i] = miso_oe;
      #HALF;
      sck = 1'b0;
    end
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic run(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                     input string tag);
    logic [15:0] mb, ob;
    int          w0, f0;
    bit          rsv, full, do_wr, exp_ferr;
    logic [3:0]  a;
    logic [7:0]  rb;
    w0   = wr_cnt;
    f0   = ferr_cnt;
    a    = cmd[3:0];
    rsv  = (cmd[6:4] != 3'd0);
    full = (nbits == 16);
    rb   = (a == 4'hF) ? stat_in : m_regs[a];
    frame(cmd, dat, nbits, mb, ob);
    do_wr    = full && cmd[7] && !rsv && (a != 4'hF);
    exp_ferr = !full && !(nbits >= 8 && rsv);
    chk({tag, ".wr_cnt"}, wr_cnt - w0, {31'd0, do_wr});
    if (do_wr) begin
      chk({tag, ".wr_val"}, {20'd0, wr_last}, {20'd0, a, dat});
      m_regs[a] = dat;
    end
    chk({tag, ".ferr"}, ferr_cnt - f0, {31'd0, exp_ferr});
    if (full) begin
      if (!cmd[7] && !rsv) begin
        chk({tag, ".miso"}, {16'd0, mb}, {24'd0, rb});
        chk({tag, ".oe"},   {16'd0, ob}, 32'h0000_00FF);
      end else begin
        chk({tag, ".miso"}, {16'd0, mb, ob}, 0);
      end
    end
    chk({tag, ".ctrl"}, {24'd0, ctrl_out}, {24'd0, m_regs[0]});
  endtask

  initial begin
    logic [15:0] mb, ob;
    int          w0, f0, k, nb;
    logic [7:0]  c, d;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

    #25;
    chk("rst.out", {miso, miso_oe, wr_stb, frame_err, ctrl_out}, 0);
    @(negedge line_clk);
    line_reset_n = 1'b1;
    repeat (10) @(negedge line_clk);

    run(8'h83, 8'h5A, 16, "wr3");
    run(8'h80, 8'hC3, 16, "wr0");
    run(8'h03, 8'h00, 16, "rd3");
    stat_in = 8'hA5;
    run(8'h0F, 8'h00, 16, "rd_stat");
    run(8'h8F, 8'h11, 16, "wr_stat");
    run(8'h85, 8'hFF, 12, "abort12");
    run(8'h05, 8'h00, 16, "rd5");
    run(8'hC2, 8'h77, 16, "rsv_wr");
    run(8'h23, 8'h00, 16, "rsv_rd");

    // status change after the command byte must not alter the byte in flight
    stat_in  = 8'h3C;
    stat_mid = 8'hC3;
    mid_en   = 1'b1;
    run(8'h0F, 8'h00, 16, "rd_stat_hold");
    mid_en   = 1'b0;

    w0 = wr_cnt;
    f0 = ferr_cnt;
    rst_bit = 9;
    frame(8'h85, 8'h77, 16, mb, ob);
    rst_bit = -1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    chk("rst_mid.wr",   wr_cnt - w0, 0);
    chk("rst_mid.ferr", ferr_cnt - f0, 0);
    chk("rst_mid.ctrl", {24'd0, ctrl_out}, 0);
    run(8'h81, 8'h22, 16, "post_rst_wr");
    run(8'h03, 8'h00, 16, "post_rst_rd3");

    for (int n = 0; n < 40; n++) begin
      stat_in = 8'($urandom);
      k  = int'($urandom_range(0, 5));
      d  = 8'($urandom);
      c  = {4'h0, 4'($urandom)};
      nb = 16;
      case (k)
        0, 1: c[7] = 1'b1;
        2:    c[7] = 1'b0;
        3: begin
          c[7]   = 1'($urandom);
          c[6:4] = 3'($urandom_range(1, 7));
        end
        4: begin
          c[7] = 1'b1;
          nb   = int'($urandom_range(2, 15));
        end
        default: c = 8'h0F;
      endcase
      run(c, d, nb, $sformatf("rnd%0d", n));
    end

    for (int i = 0; i < 15; i++) run({4'h0, 4'(i)}, 8'h00, 16, $sformatf("final_rd%0d", i));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter: NREG, 16, number of 8-bit registers; the address field is 4 bits.
REQ-002 Parameter: STAT_ADDR, 4'hF, read-only address that returns stat_in.
REQ-003 line_clk  in  1  sole clock; must be at least 8x the sck frequency.
REQ-004 line_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 sck  in  1  SPI clock from the uart2spi sck output; asynchronous to line_clk.
REQ-006 mosi  in  1  serial data in from uart2spi so.
REQ-007 cs_n  in  1  chip select, active-low; one bit of uart2spi cs_n.
REQ-008 miso  out  1  serial data out to uart2spi si.
REQ-009 miso_oe  out  1  high while a read data byte is being shifted out.
REQ-010 stat_in  in  8  status byte, readable at STAT_ADDR.
REQ-011 ctrl_out  out  8  live contents of register 0.
REQ-012 wr_stb  out  1  one-cycle pulse on every committed write.
REQ-013 wr_addr  out  4  address of the committed write; valid while wr_stb is high.
REQ-014 wr_data  out  8  data of the committed write; valid while wr_stb is high.
REQ-015 frame_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-016 sck, mosi and cs_n SHALL each pass through a 2-flop synchronizer; sck edges are detected from the synchronized value plus a third delay flop.
REQ-017 SPI mode 0, MSB first: mosi sampled on detected sck rise; miso updated on detected sck fall.
REQ-018 Frame = 16 bits: command byte, then data byte.
REQ-019 Command byte: bit7 R/W (1 = write), bits 6:4 reserved (must be 0), bits 3:0 address.
REQ-020 FSM states: IDLE, CMD, DATA, DONE.
REQ-021 IDLE -> CMD on synchronized cs_n falling; bit counter cleared.
REQ-022 CMD -> DATA after the 8th rise.
REQ-023 DATA -> DONE after the 16th rise.
REQ-024 DONE -> IDLE on synchronized cs_n high.
REQ-025 Any state other than IDLE SHALL go to IDLE on cs_n high.
REQ-026 Write: wr_stb SHALL pulse, and reg[addr] SHALL update, exactly 1 line_clk cycle after the cycle in which the 16th rise is detected.
REQ-027 Read: on the sck fall following the 8th rise, miso SHALL present bit7 of reg[addr] (or stat_in when addr = STAT_ADDR) and miso_oe SHALL go high; the remaining bits SHALL follow on successive falls.
REQ-028 Read data SHALL be captured at the 8th rise; later register changes do not alter the byte in flight.
REQ-029 miso_oe SHALL drop, and miso SHALL go to 0, on entry to DONE or IDLE.
REQ-030 A write to STAT_ADDR SHALL be ignored: no wr_stb, no register update.
REQ-031 If any reserved bit is nonzero, the frame SHALL be ignored: no write, miso held 0, miso_oe low, no frame_err.
REQ-032 cs_n high in CMD or DATA SHALL pulse frame_err for one cycle, discard the frame and produce no write.
REQ-033 cs_n high in the same cycle as the 16th rise detection: the write SHALL NOT commit and frame_err SHALL pulse.
REQ-034 sck edges in DONE or IDLE SHALL be ignored; the bit counter SHALL NOT wrap.
REQ-035 A rise and a fall are never detected in the same cycle; the design relies on REQ-003.

Reset
REQ-036 Reset SHALL clear, asynchronously: all registers, ctrl_out, the shift register, the bit counter and all synchronizer flops. Synchronizer reset values: cs_n flops to 1, sck and mosi flops to 0.
REQ-037 During and after reset: FSM = IDLE; miso, miso_oe, wr_stb and frame_err = 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no write and no frame_err; the next frame requires a fresh cs_n fall.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the command field bit positions and the STAT_ADDR default.
REQ-040 One sub-module, sync_2ff (parameterised width), SHALL be instantiated for sck, mosi and cs_n.
REQ-041 The register file SHALL be flops, not a RAM macro.

Verification
REQ-042 Write 0x83, 0x5A with line_clk = 16x sck -> one wr_stb, wr_addr = 3, wr_data = 0x5A.
REQ-043 Write 0x80, 0xC3 -> one wr_stb, wr_addr = 0, wr_data = 0xC3; ctrl_out = 0xC3.
REQ-044 After the write in REQ-042, read 0x03 -> miso bits 0,1,0,1,1,0,1,0 on bits 9-16; miso_oe high for exactly that byte.
REQ-045 stat_in = 0xA5: read 0x0F -> returns 0xA5; write 0x8F, 0x11 -> no wr_stb.
REQ-046 cs_n raised after 12 bits of write 0x85, 0xFF -> one frame_err pulse, no wr_stb, reg5 unchanged.
REQ-047 line_reset_n pulsed low during bit 10 of a write -> all outputs 0 and reg file cleared; next full frame 0x81, 0x22 -> wr_addr = 1, wr_data = 0x22.
